instr_fetch_8bit: RTL and testbench
===================================

// Module: instr_fetch_8bit
// PURPOSE
//  Read-side instruction fetch unit for the 8-bit, 512-byte instruction SRAM.
//  Drives the SRAM address, reads two consecutive bytes per 16-bit instruction,
//  and offers the result to the decode stage on a valid/ready handshake.
//  Supports PC redirect (branch), a stall while the loader owns the SRAM, and a
//  HALT stop. Sits between I-SRAM dataout and the CPU decode stage.
// PARAMETERS
//  ADDR_W    9        SRAM byte address width; PC width is ADDR_W-1
//  RESET_PC  8'h00    PC value loaded on reset
//  HALT_OP   5'b00001 opcode in instr[15:11] that stops fetching
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   reset, asynchronous, active-low
//  enable       in   1   fetch enable; sampled in IDLE and on instruction completion
//  load_busy    in   1   loader is writing the SRAM; fetch must not run
//  mem_addr     out  9   SRAM byte address, {pc, byte_sel}
//  mem_dout     in   8   SRAM dataout, combinational read of mem_addr
//  redirect     in   1   load redirect_pc and flush, one-cycle pulse
//  redirect_pc  in   8   new instruction PC
//  instr        out  16  fetched instruction, {byte[2*pc], byte[2*pc+1]}
//  instr_pc     out  8   PC of instr
//  instr_valid  out  1   instr/instr_pc are valid
//  instr_ready  in   1   decode accepts; transfer when valid && ready
//  pc           out  8   PC of the next instruction to fetch
//  halted       out  1   HALT_OP delivered; fetch stopped
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, hi_byte=0, instr=0, instr_pc=0,
//    instr_valid=0, halted=0, mem_addr={RESET_PC,1'b0}. Reset mid-op aborts immediately.
//  Byte order: high byte at even address (big-endian); mem_addr is a register-driven
//    mux of state and pc; mem_dout is sampled in the same cycle.
//  IDLE: mem_addr={pc,0}; if enable && !load_busy, go to HI.
//  HI: mem_addr={pc,0}; hi_byte<=mem_dout; go to LO.
//  LO: mem_addr={pc,1}. If !instr_valid || instr_ready (the buffer is free or
//    drains this cycle): instr<={hi_byte,mem_dout}, instr_pc<=pc, instr_valid<=1,
//    pc<=pc+1 (8-bit wrap, 8'hFF->8'h00). Next state: HALT if opcode==HALT_OP;
//    HI if enable && !load_busy; else IDLE. Otherwise stay in LO (backpressure);
//    mem_addr and pc stay unchanged.
//  Transfer: valid && ready with no new load -> instr_valid<=0 next cycle.
//  Throughput: 1 instruction per 2 cycles. Latency: enable high in IDLE ->
//    instr_valid high 3 edges later.
//  HALT: halted=1; mem_addr={pc,0}; no SRAM reads; the buffered HALT instruction
//    still hands off normally. Only redirect or reset leaves HALT.
//  Redirect has the highest priority, in any state: pc<=redirect_pc,
//    instr_valid<=0, hi_byte discarded, halted<=0; next state HI if
//    enable && !load_busy, else IDLE. A same-cycle valid&&ready counts as accepted;
//    the instruction is then dropped.
//  load_busy in HI/LO: go to IDLE; partial hi_byte discarded; pc unchanged;
//    a buffered instr/instr_valid is kept and can still be accepted.
//  enable low in HI/LO: the in-flight instruction completes, then IDLE.
//  No output goes X when memory is uninitialised; mem_dout is passed through as-is.
// TESTING
//  1 bytes[0..3]=12,34,56,78; enable=1, ready=1 -> instr 16'h1234 pc0, then
//    16'h5678 pc1, valid every 2nd cycle; mem_addr 000,001,002,003.
//  2 same, ready=0 after first valid -> instr holds 16'h1234, state LO,
//    mem_addr=003, pc=1; ready=1 -> 16'h5678 loaded the same edge it drains.
//  3 redirect, redirect_pc=8'h80 while in HI -> instr_valid=0 next cycle;
//    next instr from bytes 0x100/0x101, instr_pc=8'h80.
//  4 RESET_PC=8'hFF -> first instr from 0x1FE/0x1FF, pc wraps to 8'h00,
//    next mem_addr=9'h000.
//  5 byte[4]={HALT_OP,3'b0} -> instr_pc=2 delivered, halted=1, pc=3,
//    no further valid; redirect to 0 -> halted=0, fetch resumes at 0x000.
//  6 load_busy=1 in LO -> IDLE, no new valid, pc unchanged; rst_n low mid-HI
//    -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/instr_fetch_8bit_if.sv
// Decode-side handshake between the instruction fetch unit and the decode stage.
// The master side (fetch) offers instr/instr_pc under instr_valid; the slave side accepts with instr_ready.
interface instr_fetch_8bit_if #(
   parameter int unsigned PC_W = 8
);
   logic [15:0]     instr;
   logic [PC_W-1:0] instr_pc;
   logic            instr_valid;
   logic            instr_ready;

   modport master (
      output instr,
      output instr_pc,
      output instr_valid,
      input  instr_ready
   );

   modport slave (
      input  instr,
      input  instr_pc,
      input  instr_valid,
      output instr_ready
   );
endinterface

// File: rtl/instr_fetch_8bit.sv
// Instruction fetch for the 8-bit instruction SRAM: two big-endian byte reads per
// 16-bit instruction, buffered toward decode, with redirect, loader stall and HALT.
module instr_fetch_8bit #(
   parameter int unsigned       ADDR_W   = 9,
   parameter logic [ADDR_W-2:0] RESET_PC = '0,
   parameter logic [4:0]        HALT_OP  = 5'b00001
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              load_busy,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_dout,
   input  logic              redirect,
   input  logic [ADDR_W-2:0] redirect_pc,
   instr_fetch_8bit_if.master dec,
   output logic [ADDR_W-2:0] pc,
   output logic              halted
);

   typedef enum logic [1:0] {IDLE, HI, LO, HALT} state_t;

   state_t            state;
   logic [7:0]        hi_byte;
   logic [15:0]       instr_q;
   logic [ADDR_W-2:0] instr_pc_q;
   logic              instr_valid_q;

   logic run;
   logic accept;
   logic buf_free;

   assign run      = enable && !load_busy;
   assign accept   = instr_valid_q && dec.instr_ready;
   assign buf_free = !instr_valid_q || dec.instr_ready;

   // Byte select is the low address bit; only LO reads the odd byte.
   assign mem_addr = {pc, (state == LO)};

   assign dec.instr       = instr_q;
   assign dec.instr_pc    = instr_pc_q;
   assign dec.instr_valid = instr_valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         pc            <= RESET_PC;
         hi_byte       <= '0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         halted        <= 1'b0;
      end else begin
         // A handshake drains the buffer unless a new instruction lands on the same edge.
         if (accept)
            instr_valid_q <= 1'b0;

         if (redirect) begin
            pc            <= redirect_pc;
            instr_valid_q <= 1'b0;
            hi_byte       <= '0;
            halted        <= 1'b0;
            state         <= run ? HI : IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (run)
                     state <= HI;
               end
               HI: begin
                  if (load_busy) begin
                     hi_byte <= '0;
                     state   <= IDLE;
                  end else begin
                     hi_byte <= mem_dout;
                     state   <= LO;
                  end
               end
               LO: begin
                  if (load_busy) begin
                     hi_byte <= '0;
                     state   <= IDLE;
                  end else if (buf_free) begin
                     instr_q       <= {hi_byte, mem_dout};
                     instr_pc_q    <= pc;
                     instr_valid_q <= 1'b1;
                     pc            <= pc + 1'b1;
                     if (hi_byte[7:3] == HALT_OP) begin
                        halted <= 1'b1;
                        state  <= HALT;
                     end else begin
                        state <= run ? HI : IDLE;
                     end
                  end
               end
               HALT: begin
                  state <= HALT;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_8bit.sv
// Directed and randomized checks of instr_fetch_8bit against byte-level SRAM contents
// and a transaction-level stream model (expected instruction = bytes at 2*pc, 2*pc+1).
module tb_instr_fetch_8bit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       load_busy = 1'b0;
   logic       redirect = 1'b0;
   logic [7:0] redirect_pc = '0;
   logic [8:0] mem_addr0;
   logic [7:0] mem_dout0;
   logic [7:0] pc0;
   logic       halted0;

   logic       en1 = 1'b0;
   logic       zero = 1'b0;
   logic [7:0] zero_pc = '0;
   logic [8:0] mem_addr1;
   logic [7:0] mem_dout1;
   logic [7:0] pc1;
   logic       halted1;

   logic [7:0] mem [0:511];

   int errors = 0;
   int checks = 0;

   instr_fetch_8bit_if #(.PC_W(8)) dec0 ();
   instr_fetch_8bit_if #(.PC_W(8)) dec1 ();

   assign mem_dout0 = mem[mem_addr0];
   assign mem_dout1 = mem[mem_addr1];
   assign dec1.instr_ready = 1'b1;

   instr_fetch_8bit dut0 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load_busy(load_busy),
      .mem_addr(mem_addr0), .mem_dout(mem_dout0), .redirect(redirect),
      .redirect_pc(redirect_pc), .dec(dec0.master), .pc(pc0), .halted(halted0)
   );

   instr_fetch_8bit #(.RESET_PC(8'hFF)) dut1 (
      .clk(clk), .rst_n(rst_n), .enable(en1), .load_busy(zero),
      .mem_addr(mem_addr1), .mem_dout(mem_dout1), .redirect(zero),
      .redirect_pc(zero_pc), .dec(dec1.master), .pc(pc1), .halted(halted1)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      enable = 1'b0; en1 = 1'b0; load_busy = 1'b0; redirect = 1'b0;
      dec0.instr_ready = 1'b1;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic load_basic();
      for (int unsigned a = 0; a < 512; a++) mem[a] = 8'h00;
      mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
      mem[4] = 8'h9A; mem[5] = 8'hBC; mem[6] = 8'hDE; mem[7] = 8'hF0;
      mem[9'h100] = 8'hAB; mem[9'h101] = 8'hCD;
      mem[9'h1FE] = 8'hA5; mem[9'h1FF] = 8'h5A;
   endtask

   initial begin
      logic [7:0]  exp_pc;
      logic [7:0]  rp;
      logic [15:0] held;
      logic        have_hold;
      logic        rdy;
      logic        redir;
      int          ntx;

      load_basic();
      dec0.instr_ready = 1'b1;
      do_reset();

      // reset values
      chk("rst_valid", dec0.instr_valid, 1'b0);
      chk("rst_instr", dec0.instr, 16'h0000);
      chk("rst_instr_pc", dec0.instr_pc, 8'h00);
      chk("rst_pc", pc0, 8'h00);
      chk("rst_halted", halted0, 1'b0);
      chk("rst_addr", mem_addr0, 9'h000);

      // RESET_PC = 8'hFF: fetch from 0x1FE/0x1FF and wrap
      chk("wrap_rst_addr", mem_addr1, 9'h1FE);
      chk("wrap_rst_pc", pc1, 8'hFF);
      en1 = 1'b1;
      tick(); tick(); tick();
      chk("wrap_valid", dec1.instr_valid, 1'b1);
      chk("wrap_instr", dec1.instr, 16'hA55A);
      chk("wrap_instr_pc", dec1.instr_pc, 8'hFF);
      chk("wrap_pc", pc1, 8'h00);
      chk("wrap_addr", mem_addr1, 9'h000);
      en1 = 1'b0;

      // streaming with ready held high
      do_reset();
      enable = 1'b1;
      chk("t1_addr0", mem_addr0, 9'h000);
      tick();
      chk("t1_addr_hi", mem_addr0, 9'h000);
      chk("t1_valid_e1", dec0.instr_valid, 1'b0);
      tick();
      chk("t1_addr_lo", mem_addr0, 9'h001);
      chk("t1_valid_e2", dec0.instr_valid, 1'b0);
      tick();
      chk("t1_valid_e3", dec0.instr_valid, 1'b1);
      chk("t1_instr0", dec0.instr, 16'h1234);
      chk("t1_instr_pc0", dec0.instr_pc, 8'h00);
      chk("t1_pc", pc0, 8'h01);
      chk("t1_addr2", mem_addr0, 9'h002);
      tick();
      chk("t1_valid_e4", dec0.instr_valid, 1'b0);
      chk("t1_addr3", mem_addr0, 9'h003);
      tick();
      chk("t1_valid_e5", dec0.instr_valid, 1'b1);
      chk("t1_instr1", dec0.instr, 16'h5678);
      chk("t1_instr_pc1", dec0.instr_pc, 8'h01);

      // backpressure after the first instruction
      do_reset();
      enable = 1'b1;
      tick(); tick(); tick();
      chk("t2_instr0", dec0.instr, 16'h1234);
      dec0.instr_ready = 1'b0;
      tick(); tick();
      chk("t2_hold_valid", dec0.instr_valid, 1'b1);
      chk("t2_hold_instr", dec0.instr, 16'h1234);
      chk("t2_hold_addr", mem_addr0, 9'h003);
      chk("t2_hold_pc", pc0, 8'h01);
      dec0.instr_ready = 1'b1;
      tick();
      chk("t2_reload_valid", dec0.instr_valid, 1'b1);
      chk("t2_reload_instr", dec0.instr, 16'h5678);
      chk("t2_reload_pc", dec0.instr_pc, 8'h01);
      chk("t2_pc", pc0, 8'h02);

      // redirect while in HI flushes a pending instruction
      dec0.instr_ready = 1'b0;
      redirect = 1'b1; redirect_pc = 8'h80;
      tick();
      redirect = 1'b0;
      chk("t3_flush_valid", dec0.instr_valid, 1'b0);
      chk("t3_pc", pc0, 8'h80);
      chk("t3_addr_hi", mem_addr0, 9'h100);
      tick();
      chk("t3_addr_lo", mem_addr0, 9'h101);
      tick();
      chk("t3_valid", dec0.instr_valid, 1'b1);
      chk("t3_instr", dec0.instr, 16'hABCD);
      chk("t3_instr_pc", dec0.instr_pc, 8'h80);
      dec0.instr_ready = 1'b1;

      // HALT at pc 2
      mem[4] = 8'h08; mem[5] = 8'h55;
      do_reset();
      enable = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      chk("t5_valid", dec0.instr_valid, 1'b1);
      chk("t5_instr", dec0.instr, 16'h0855);
      chk("t5_instr_pc", dec0.instr_pc, 8'h02);
      chk("t5_halted", halted0, 1'b1);
      chk("t5_pc", pc0, 8'h03);
      chk("t5_addr", mem_addr0, 9'h006);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t5_no_valid", dec0.instr_valid, 1'b0);
      end
      chk("t5_still_halted", halted0, 1'b1);
      chk("t5_halt_pc", pc0, 8'h03);
      redirect = 1'b1; redirect_pc = 8'h00;
      tick();
      redirect = 1'b0;
      chk("t5_unhalt", halted0, 1'b0);
      chk("t5_resume_pc", pc0, 8'h00);
      chk("t5_resume_addr", mem_addr0, 9'h000);
      tick(); tick();
      chk("t5_resume_valid", dec0.instr_valid, 1'b1);
      chk("t5_resume_instr", dec0.instr, 16'h1234);

      // loader stall in LO, then asynchronous reset in HI
      tick();
      chk("t6_lo_addr", mem_addr0, 9'h003);
      load_busy = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("t6_busy_valid", dec0.instr_valid, 1'b0);
         chk("t6_busy_addr", mem_addr0, 9'h002);
         chk("t6_busy_pc", pc0, 8'h01);
      end
      load_busy = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("t6_arst_valid", dec0.instr_valid, 1'b0);
      chk("t6_arst_instr", dec0.instr, 16'h0000);
      chk("t6_arst_instr_pc", dec0.instr_pc, 8'h00);
      chk("t6_arst_pc", pc0, 8'h00);
      chk("t6_arst_addr", mem_addr0, 9'h000);
      chk("t6_arst_halted", halted0, 1'b0);

      // randomized stream against the byte-pair model
      for (int unsigned a = 0; a < 512; a++) begin
         mem[a] = 8'($urandom);
         while (a[0] == 1'b0 && mem[a][7:3] == 5'b00001) mem[a] = 8'($urandom);
      end
      do_reset();
      enable = 1'b1;
      rp = 8'($urandom);
      redirect = 1'b1; redirect_pc = rp;
      exp_pc = rp;
      tick();
      redirect = 1'b0;
      have_hold = 1'b0;
      ntx = 0;
      for (int i = 0; i < 400; i++) begin
         if (have_hold) begin
            chk("rnd_hold_valid", dec0.instr_valid, 1'b1);
            chk("rnd_hold_instr", dec0.instr, held);
            have_hold = 1'b0;
         end
         rdy   = 1'($urandom_range(0, 1));
         redir = ($urandom_range(0, 29) == 0);
         dec0.instr_ready = rdy;
         if (dec0.instr_valid && rdy) begin
            chk("rnd_instr", dec0.instr, {mem[{exp_pc, 1'b0}], mem[{exp_pc, 1'b1}]});
            chk("rnd_instr_pc", dec0.instr_pc, exp_pc);
            exp_pc = exp_pc + 8'd1;
            ntx++;
         end else if (dec0.instr_valid && !redir) begin
            have_hold = 1'b1;
            held = dec0.instr;
         end
         if (redir) begin
            rp = 8'($urandom);
            redirect = 1'b1; redirect_pc = rp;
            exp_pc = rp;
         end else begin
            redirect = 1'b0;
         end
         tick();
      end
      redirect = 1'b0;
      chk("rnd_progress", (ntx >= 50), 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
